grid_pmgen: RTL and testbench

//  Duty-cycle sequencer feeding the PWM stage's PM stream input (asi_pm_*).

---
 rtl/grid_pmgen_pkg.sv | 40 ++++
 rtl/grid_pmgen_ram.sv | 31 +++
 rtl/grid_pmgen.sv | 194 +++++++++++++++++++
 tb/tb_grid_pmgen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pmgen_pkg.sv
// Shared constants for the grid_pmgen duty-cycle sequencer: register map, CTRL bit
// positions, ID value, FSM state encoding and a byte-enable merge helper.
package grid_pmgen_pkg;

    localparam logic [2:0] AddrSize  = 3'd0;
    localparam logic [2:0] AddrId    = 3'd1;
    localparam logic [2:0] AddrCtrl  = 3'd2;
    localparam logic [2:0] AddrPrd   = 3'd3;
    localparam logic [2:0] AddrLen   = 3'd4;
    localparam logic [2:0] AddrTaddr = 3'd5;
    localparam logic [2:0] AddrTdata = 3'd6;

    localparam logic [31:0] SizeValue = 32'd32;
    localparam logic [31:0] IdValue   = 32'hEA68_0003;

    localparam int unsigned CtrlRunBit   = 0;
    localparam int unsigned CtrlIrqEnBit = 1;
    localparam int unsigned CtrlLoopBit  = 8;
    localparam int unsigned CtrlDoneBit  = 16;
    localparam int unsigned CtrlOvrBit   = 24;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StPush,
        StWait
    } state_e;

    function automatic logic [31:0] be_merge(logic [31:0] old_val, logic [31:0] wdata,
                                             logic [3:0] be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/grid_pmgen_ram.sv
// Sample table: DEPTH x DW simple dual-port RAM, bit-masked write port, registered read.
// A same-address read during a write returns the old contents.
module grid_pmgen_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [DW-1:0] wmask_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < int'(DW); i++) begin
                if (wmask_i[i]) mem_q[waddr_i][i] <= wdata_i[i];
            end
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/grid_pmgen.sv
// grid_pmgen: plays a host-loaded duty table as an Avalon-ST source at a programmed period.
// Optional interrupt output enabled by defining GRID_PMGEN_IRQ_EN.
module grid_pmgen
    import grid_pmgen_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned DW    = 32
) (
    input  logic          csi_MCLK_clk,
    input  logic          rsi_MRST_reset,
    input  logic [2:0]    avs_pmgen_address,
    input  logic [31:0]   avs_pmgen_writedata,
    input  logic [3:0]    avs_pmgen_byteenable,
    input  logic          avs_pmgen_write,
    input  logic          avs_pmgen_read,
    output logic [31:0]   avs_pmgen_readdata,
    output logic          avs_pmgen_waitrequest,
    output logic [DW-1:0] aso_pm_data,
    output logic          aso_pm_valid,
    input  logic          aso_pm_ready
`ifdef GRID_PMGEN_IRQ_EN
    ,
    output logic          ins_irq_irq
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e        state_q;
    logic [AW-1:0] idx_q, len_q, len_d, taddr_q, taddr_d;
    logic [31:0]   cnt_q, prd_q, prd_d, readdata_q, rd_val, wmask;
    logic [DW-1:0] pm_data_q, ram_rdata;
    logic          pm_valid_q;
    logic          run_q, run_d, loop_q, loop_d, done_q, done_d, ovr_q, ovr_d;
    logic          wr_ctrl, wr_prd, wr_len, wr_taddr, wr_tdata;
    logic          accept, last, finish, tick, overrun;
    logic [3:0]    be;
    logic [31:0]   wd;

    assign be       = avs_pmgen_byteenable;
    assign wd       = avs_pmgen_writedata;
    assign wr_ctrl  = avs_pmgen_write && (avs_pmgen_address == AddrCtrl);
    assign wr_prd   = avs_pmgen_write && (avs_pmgen_address == AddrPrd);
    assign wr_len   = avs_pmgen_write && (avs_pmgen_address == AddrLen);
    assign wr_taddr = avs_pmgen_write && (avs_pmgen_address == AddrTaddr);
    assign wr_tdata = avs_pmgen_write && (avs_pmgen_address == AddrTdata);
    assign wmask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    assign accept  = (state_q == StPush) && pm_valid_q && aso_pm_ready;
    assign last    = (idx_q == len_q);
    assign finish  = accept && last && !loop_q;
    assign tick    = (state_q != StIdle) && (cnt_q == prd_q);
    assign overrun = tick && (state_q inside {StFetch, StLoad, StPush});

    grid_pmgen_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_ram (
        .clk_i   (csi_MCLK_clk),
        .we_i    (wr_tdata),
        .waddr_i (taddr_q),
        .wdata_i (DW'(wd)),
        .wmask_i (DW'(wmask)),
        .raddr_i (idx_q),
        .rdata_o (ram_rdata)
    );

`ifdef GRID_PMGEN_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q;
    assign irq_en_d    = (wr_ctrl && be[0]) ? wd[CtrlIrqEnBit] : irq_en_q;
    assign ins_irq_irq = irq_q;
`endif

    // Host write of run wins over the self-clear; a hardware set of done/ovr wins over W1C.
    always_comb begin
        run_d = run_q;
        if (finish) run_d = 1'b0;
        if (wr_ctrl && be[0]) run_d = wd[CtrlRunBit];
        loop_d = (wr_ctrl && be[1]) ? wd[CtrlLoopBit] : loop_q;
        done_d = done_q;
        if (wr_ctrl && be[2] && wd[CtrlDoneBit]) done_d = 1'b0;
        if (finish) done_d = 1'b1;
        ovr_d = ovr_q;
        if (wr_ctrl && be[3] && wd[CtrlOvrBit]) ovr_d = 1'b0;
        if (overrun) ovr_d = 1'b1;
        prd_d = wr_prd ? be_merge(prd_q, wd, be) : prd_q;
        len_d = wr_len ? AW'(be_merge(32'(len_q), wd, be)) : len_q;
        taddr_d = taddr_q;
        if (wr_taddr) taddr_d = AW'(be_merge(32'(taddr_q), wd, be));
        else if (wr_tdata) taddr_d = taddr_q + AW'(1);
    end

    always_comb begin
        rd_val = '0;
        case (avs_pmgen_address)
            AddrSize:  rd_val = SizeValue;
            AddrId:    rd_val = IdValue;
            AddrCtrl: begin
                rd_val[CtrlRunBit]  = run_q;
                rd_val[CtrlLoopBit] = loop_q;
                rd_val[CtrlDoneBit] = done_q;
                rd_val[CtrlOvrBit]  = ovr_q;
`ifdef GRID_PMGEN_IRQ_EN
                rd_val[CtrlIrqEnBit] = irq_en_q;
`endif
            end
            AddrPrd:   rd_val = prd_q;
            AddrLen:   rd_val = 32'(len_q);
            AddrTaddr: rd_val = 32'(taddr_q);
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            run_q      <= 1'b0;
            loop_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            prd_q      <= '0;
            len_q      <= '0;
            taddr_q    <= '0;
            readdata_q <= '0;
`ifdef GRID_PMGEN_IRQ_EN
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
`endif
        end else begin
            run_q   <= run_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            prd_q   <= prd_d;
            len_q   <= len_d;
            taddr_q <= taddr_d;
            if (avs_pmgen_read) readdata_q <= rd_val;
`ifdef GRID_PMGEN_IRQ_EN
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_q && (done_q || ovr_q);
`endif
        end
    end

    // Any cycle where run ends up low forces the sequencer idle and drops a pending sample.
    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            cnt_q      <= '0;
            pm_data_q  <= '0;
            pm_valid_q <= 1'b0;
        end else if (!run_d) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            cnt_q      <= '0;
            pm_valid_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == StIdle || tick) ? '0 : cnt_q + 32'd1;
            case (state_q)
                StIdle: begin
                    idx_q <= '0;
                    if (run_q) state_q <= StFetch;
                end
                StFetch: state_q <= StLoad;
                StLoad: begin
                    pm_data_q  <= ram_rdata;
                    pm_valid_q <= 1'b1;
                    state_q    <= StPush;
                end
                StPush: begin
                    if (accept) begin
                        pm_valid_q <= 1'b0;
                        if (!last) begin
                            idx_q   <= idx_q + AW'(1);
                            state_q <= StWait;
                        end else begin
                            idx_q   <= '0;
                            state_q <= loop_q ? StWait : StIdle;
                        end
                    end
                end
                StWait: if (tick) state_q <= StFetch;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign avs_pmgen_readdata    = readdata_q;
    assign avs_pmgen_waitrequest = 1'b0;
    assign aso_pm_data           = pm_data_q;
    assign aso_pm_valid          = pm_valid_q;

endmodule

// File: tb/tb_grid_pmgen.sv
// Directed bench for grid_pmgen: scoreboard of expected stream samples plus register checks.
`timescale 1ns/1ps
module tb_grid_pmgen;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    addr;
    logic [31:0]   wdata;
    logic [3:0]    be_s;
    logic          wr, rd;
    logic [31:0]   readdata;
    logic          waitreq;
    logic [DW-1:0] pm_data;
    logic          pm_valid, pm_ready;
`ifdef GRID_PMGEN_IRQ_EN
    logic          irq;
`endif

    always #5 clk = ~clk;

    grid_pmgen #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) dut (
        .csi_MCLK_clk          (clk),
        .rsi_MRST_reset        (rst),
        .avs_pmgen_address     (addr),
        .avs_pmgen_writedata   (wdata),
        .avs_pmgen_byteenable  (be_s),
        .avs_pmgen_write       (wr),
        .avs_pmgen_read        (rd),
        .avs_pmgen_readdata    (readdata),
        .avs_pmgen_waitrequest (waitreq),
        .aso_pm_data           (pm_data),
        .aso_pm_valid          (pm_valid),
        .aso_pm_ready          (pm_ready)
`ifdef GRID_PMGEN_IRQ_EN
        ,
        .ins_irq_irq           (irq)
`endif
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] exp_q[$];
    bit          spacing_en = 1'b0;
    int          last_acc   = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted beat is compared against the oldest expected sample.
    always @(negedge clk) begin
        if (!rst && pm_valid && pm_ready) begin
            chk("sample_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("sample_data", pm_data, exp_q.pop_front());
            if (spacing_en) begin
                if (last_acc >= 0) chk("sample_spacing", 32'(cyc - last_acc), 32'd5);
                last_acc = cyc;
            end
        end
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
        @(posedge clk); #1;
        addr = a; wdata = d; be_s = b; wr = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0; be_s = 4'h0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        addr = a; rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        d = readdata;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (pm_valid !== 1'b1 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, 32'(pm_valid), 32'd1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        bit          stable;

        rst = 1'b1; addr = '0; wdata = '0; be_s = '0; wr = 1'b0; rd = 1'b0; pm_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_readdata", readdata, 32'd0);
        chk("reset_valid", 32'(pm_valid), 32'd0);
        chk("reset_data", pm_data, 32'd0);
        chk("waitrequest", 32'(waitreq), 32'd0);
        rst = 1'b0;
        bus_read(3'd2, r);
        chk("reset_ctrl", r, 32'd0);

        // One-shot playback at 5-cycle spacing.
        bus_write(3'd5, 32'd0, 4'hF);
        bus_write(3'd6, 32'd10, 4'hF);
        bus_write(3'd6, 32'd20, 4'hF);
        bus_write(3'd6, 32'd30, 4'hF);
        bus_write(3'd6, 32'd40, 4'hF);
        bus_write(3'd3, 32'd4, 4'hF);
        bus_write(3'd4, 32'd3, 4'hF);
        exp_q.push_back(32'd10); exp_q.push_back(32'd20);
        exp_q.push_back(32'd30); exp_q.push_back(32'd40);
        spacing_en = 1'b1;
        last_acc = -1;
        bus_write(3'd2, 32'h0000_0001, 4'hF);
        wait_drain("t1_drain", 100);
        spacing_en = 1'b0;
        repeat (3) @(posedge clk);
        bus_read(3'd2, r);
        chk("t1_ctrl_done", r, 32'h0001_0000);
        chk("t1_valid_low", 32'(pm_valid), 32'd0);

        // Byte enables on PRD and on the done W1C lane.
        bus_write(3'd3, 32'hFFFF_FFFF, 4'b0001);
        bus_read(3'd3, r);
        chk("t5_prd_be", r, 32'h0000_00FF);
        bus_write(3'd2, 32'h0001_0000, 4'b1011);
        bus_read(3'd2, r);
        chk("t5_done_kept", r, 32'h0001_0000);
        bus_write(3'd2, 32'h0001_0000, 4'b0100);
        bus_read(3'd2, r);
        chk("t5_done_clr", r, 32'd0);
        bus_write(3'd3, 32'd4, 4'hF);

        // Looping playback, then abort while a sample is pending.
        exp_q.push_back(32'd10); exp_q.push_back(32'd20); exp_q.push_back(32'd30);
        exp_q.push_back(32'd40); exp_q.push_back(32'd10); exp_q.push_back(32'd20);
        bus_write(3'd2, 32'h0000_0101, 4'hF);
        wait_drain("t2_drain", 200);
        #1 pm_ready = 1'b0;
        wait_valid("t2_push", 50);
        bus_write(3'd2, 32'h0000_0100, 4'hF);
        chk("t2_abort_valid", 32'(pm_valid), 32'd0);
        bus_read(3'd2, r);
        chk("t2_ctrl", r & 32'h0001_0101, 32'h0000_0100);
        pm_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("t2_stay_idle", 32'(pm_valid), 32'd0);
        bus_write(3'd2, 32'h0101_0000, 4'b1100);
        bus_write(3'd2, 32'h0000_0000, 4'hF);
        bus_read(3'd2, r);
        chk("t2_ctrl_clr", r, 32'd0);

        // PRD=0 with a stalled sink: data holds, overrun flags.
        bus_write(3'd3, 32'd0, 4'hF);
        pm_ready = 1'b0;
        exp_q.push_back(32'd10); exp_q.push_back(32'd20);
        exp_q.push_back(32'd30); exp_q.push_back(32'd40);
        bus_write(3'd2, 32'h0000_0001, 4'hF);
        wait_valid("t3_valid", 50);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pm_data !== 32'd10 || pm_valid !== 1'b1) stable = 1'b0;
        end
        chk("t3_hold", 32'(stable), 32'd1);
        bus_read(3'd2, r);
        chk("t3_ovr", 32'(r[24]), 32'd1);
        pm_ready = 1'b1;
        wait_drain("t3_drain", 100);
        repeat (3) @(posedge clk);
        bus_read(3'd2, r);
        chk("t3_ctrl", r, 32'h0101_0000);
        bus_write(3'd2, 32'h0101_0000, 4'b1100);

        // Full-table fill, pointer wrap, LEN truncation and a 256-sample sweep.
        bus_write(3'd5, 32'd0, 4'hF);
        for (int i = 0; i < int'(DEPTH); i++) bus_write(3'd6, 32'(i * 3 + 1), 4'hF);
        bus_read(3'd5, r);
        chk("t4_fill_wrap", r, 32'd0);
        bus_write(3'd5, 32'(DEPTH - 1), 4'hF);
        bus_write(3'd6, 32'hA5A5_0001, 4'hF);
        bus_write(3'd6, 32'h5A5A_0002, 4'hF);
        bus_read(3'd5, r);
        chk("t4_taddr_wrap", r, 32'd1);
        bus_read(3'd6, r);
        chk("t4_tdata_rd", r, 32'd0);
        bus_read(3'd7, r);
        chk("t4_unused_rd", r, 32'd0);
        bus_read(3'd0, r);
        chk("t4_size", r, 32'd32);
        bus_read(3'd1, r);
        chk("t4_id", r, 32'hEA68_0003);
        bus_write(3'd4, 32'h0000_01FF, 4'hF);
        bus_read(3'd4, r);
        chk("t4_len_trunc", r, 32'(DEPTH - 1));
        exp_q.push_back(32'h5A5A_0002);
        for (int i = 1; i < int'(DEPTH) - 1; i++) exp_q.push_back(32'(i * 3 + 1));
        exp_q.push_back(32'hA5A5_0001);
        bus_write(3'd2, 32'h0000_0001, 4'hF);
        wait_drain("t4_drain", 3000);
        repeat (3) @(posedge clk);
        bus_read(3'd2, r);
        chk("t4_ctrl", r & 32'h0001_0001, 32'h0001_0000);
        bus_write(3'd2, 32'h0101_0000, 4'b1100);

`ifdef GRID_PMGEN_IRQ_EN
        bus_write(3'd4, 32'd0, 4'hF);
        bus_write(3'd3, 32'd4, 4'hF);
        exp_q.push_back(32'h5A5A_0002);
        bus_write(3'd2, 32'h0000_0003, 4'hF);
        wait_drain("t6_drain", 100);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_irq_set", 32'(irq), 32'd1);
        bus_write(3'd2, 32'h0101_0002, 4'hF);
        @(posedge clk); #1;
        chk("t6_irq_clr", 32'(irq), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
